// File: rtl/cnn_buf_pkg.sv
// Shared defaults and packed-port slicing helper for the CNN feature-map buffers.
package cnn_buf_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_DEPTH      = 1024;
  localparam int unsigned DEF_ADDR_WIDTH = 13;
  localparam int unsigned DEF_NPORT      = 25;

  // Low bit of port i in a packed bus of w-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/buf_bank.sv
// One feature-map bank: single write port, NPORT registered read ports,
// out-of-range addresses are dropped on write and read back as zero.
module buf_bank
  import cnn_buf_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NPORT      = DEF_NPORT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        re,
  input  logic [NPORT*ADDR_WIDTH-1:0] raddr_np,
  output logic [NPORT*WIDTH-1:0]      rdata_np
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // Storage is deliberately not reset; ownership flags in the top gate access.
  always_ff @(posedge clk) begin
    if (we && in_range(waddr)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_np <= '0;
    end else if (re) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (in_range(raddr_np[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH])) begin
          rdata_np[slice_lo(i, WIDTH) +: WIDTH] <=
            mem[raddr_np[slice_lo(i, ADDR_WIDTH) +: IDX_W]];
        end else begin
          rdata_np[slice_lo(i, WIDTH) +: WIDTH] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/pingpong_data_buf.sv
// Ping-pong feature-map buffer: producer fills one bank while the convolution
// engine reads the other; banks change hands on wr_done / rd_done pulses.
module pingpong_data_buf
  import cnn_buf_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NPORT      = DEF_NPORT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        wr_done,
  output logic                        wr_ready,
  input  logic                        rd_en,
  input  logic [NPORT*ADDR_WIDTH-1:0] rd_addr_np,
  output logic [NPORT*WIDTH-1:0]      rd_data_np,
  output logic                        rd_valid,
  input  logic                        rd_done,
  output logic                        rd_avail,
  output logic                        err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [1:0]             full;
  logic                   wr_sel;
  logic                   rd_sel;
  logic                   rd_sel_q;
  logic                   rd_zero_q;
  logic                   wr_oor;
  logic                   rd_oor;
  logic [1:0]             bank_we;
  logic [1:0]             bank_re;
  logic [NPORT*WIDTH-1:0] bank_rdata [2];

  assign wr_ready = !full[wr_sel];
  assign rd_avail = full[rd_sel];
  assign wr_oor   = {1'b0, wr_addr} >= DEPTH_L;

  always_comb begin
    rd_oor = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if ({1'b0, rd_addr_np[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH]} >= DEPTH_L) begin
        rd_oor = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_en && wr_ready && !wr_oor && (wr_sel == 1'(b));
    assign bank_re[b] = rd_en && rd_avail && (rd_sel == 1'(b));

    buf_bank #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NPORT      (NPORT)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (bank_we[b]),
      .waddr    (wr_addr),
      .wdata    (wr_data),
      .re       (bank_re[b]),
      .raddr_np (rd_addr_np),
      .rdata_np (bank_rdata[b])
    );
  end

  // When both dones are valid together they always address different banks,
  // so the two flag updates never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_zero_q <= 1'b0;
      rd_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_sel_q  <= rd_sel;
        rd_zero_q <= !rd_avail;
      end
      if (wr_done && wr_ready) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= !wr_sel;
      end
      if (rd_done && rd_avail) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= !rd_sel;
      end
      if ((wr_en && (!wr_ready || wr_oor)) || (wr_done && !wr_ready) ||
          (rd_en && (!rd_avail || rd_oor)) || (rd_done && !rd_avail)) begin
        err <= 1'b1;
      end
    end
  end

  // Bank output registers only move on their own reads, so the mux holds
  // the last result while rd_valid is low.
  assign rd_data_np = rd_zero_q ? '0 : bank_rdata[rd_sel_q];

endmodule

// File: tb/tb_pingpong_data_buf.sv
// Self-checking bench for pingpong_data_buf against a frame-count reference model.
module tb_pingpong_data_buf;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 1024;
  localparam int unsigned AW = 13;
  localparam int unsigned NP = 25;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [W-1:0]     wr_data = '0;
  logic             wr_done = 1'b0;
  logic             wr_ready;
  logic             rd_en = 1'b0;
  logic [NP*AW-1:0] rd_addr_np = '0;
  logic [NP*W-1:0]  rd_data_np;
  logic             rd_valid;
  logic             rd_done = 1'b0;
  logic             rd_avail;
  logic             err;

  always #5 clk = ~clk;

  pingpong_data_buf #(
    .WIDTH      (W),
    .DEPTH      (D),
    .ADDR_WIDTH (AW),
    .NPORT      (NP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr_np (rd_addr_np),
    .rd_data_np (rd_data_np),
    .rd_valid   (rd_valid),
    .rd_done    (rd_done),
    .rd_avail   (rd_avail),
    .err        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: banks alternate, so frame counts alone define ownership.
  logic [W-1:0] mdl_mem [2][D];
  int unsigned  frames_in;
  int unsigned  frames_out;
  logic         mdl_err;
  logic         mdl_valid;
  logic [W-1:0] mdl_rd [NP];

  function automatic logic mdl_ready();
    return (frames_in - frames_out) < 2;
  endfunction

  function automatic logic mdl_avail();
    return (frames_in - frames_out) > 0;
  endfunction

  function automatic logic [NP*W-1:0] mdl_vec();
    logic [NP*W-1:0] v;
    for (int p = 0; p < NP; p++) v[p*W +: W] = mdl_rd[p];
    return v;
  endfunction

  task automatic model_reset();
    frames_in  = 0;
    frames_out = 0;
    mdl_err    = 1'b0;
    mdl_valid  = 1'b0;
    for (int p = 0; p < NP; p++) mdl_rd[p] = '0;
  endtask

  task automatic set_port(input int p, input int unsigned a);
    rd_addr_np[p*AW +: AW] = AW'(a);
  endtask

  task automatic rand_ports(input int unsigned limit);
    for (int p = 0; p < NP; p++) set_port(p, $urandom_range(limit - 1, 0));
  endtask

  // Advance one clock and apply the inputs seen at that edge to the model.
  task automatic tick();
    logic        ready;
    logic        avail;
    int unsigned a;
    @(posedge clk);
    ready = mdl_ready();
    avail = mdl_avail();
    mdl_valid = rd_en;
    if (rd_en) begin
      for (int p = 0; p < NP; p++) begin
        a = int'(rd_addr_np[p*AW +: AW]);
        if (!avail || a >= D) mdl_rd[p] = '0;
        else mdl_rd[p] = mdl_mem[frames_out % 2][a];
        if (!avail || a >= D) mdl_err = 1'b1;
      end
    end
    if (wr_en) begin
      if (!ready || int'(wr_addr) >= D) mdl_err = 1'b1;
      else mdl_mem[frames_in % 2][wr_addr] = wr_data;
    end
    if (wr_done) begin
      if (ready) frames_in++;
      else mdl_err = 1'b1;
    end
    if (rd_done) begin
      if (avail) frames_out++;
      else mdl_err = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill(input int unsigned base, input bit rnd);
    for (int unsigned a = 0; a < D; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a);
      wr_data = rnd ? W'($urandom) : W'(base + a);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_wr_done();
    wr_done = 1'b1; tick(); wr_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    n_cmp++; if (rd_avail !== 1'b0) begin n_bad++; $display("FAIL reset_rd_avail got %b exp 0", rd_avail); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_cmp++; if (rd_data_np !== '0) begin n_bad++; $display("FAIL reset_rd_data got %h exp 0", rd_data_np); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_fill_read();
    fill(0, 1'b0);
    pulse_wr_done();
    n_cmp++; if (rd_avail !== 1'b1) begin n_bad++; $display("FAIL fill_rd_avail got %b exp 1", rd_avail); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL fill_wr_ready got %b exp 1", wr_ready); end
    for (int p = 0; p < NP; p++) set_port(p, p);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL read_valid got %b exp 1", rd_valid); end
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (rd_data_np[p*W +: W] !== W'(p)) begin
        n_bad++; $display("FAIL read_port%0d got %h exp %h", p, rd_data_np[p*W +: W], W'(p));
      end
    end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL read_valid_drop got %b exp 0", rd_valid); end
    n_cmp++; if (rd_data_np !== mdl_vec()) begin n_bad++; $display("FAIL read_hold got %h exp %h", rd_data_np, mdl_vec()); end
  endtask

  task automatic test_full_drop();
    fill(0, 1'b1);
    pulse_wr_done();
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL full_wr_ready got %b exp 0", wr_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err_before got %b exp 0", err); end
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 16'hBEEF; tick(); wr_en = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL full_drop_err got %b exp 1", err); end
    set_port(0, 7);
    for (int p = 1; p < NP; p++) set_port(p, $urandom_range(D - 1, 0));
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++; if (rd_data_np[0 +: W] !== 16'h0007) begin n_bad++; $display("FAIL full_addr7 got %h exp 0007", rd_data_np[0 +: W]); end
    n_cmp++; if (rd_data_np !== mdl_vec()) begin n_bad++; $display("FAIL full_readback got %h exp %h", rd_data_np, mdl_vec()); end
  endtask

  task automatic test_pingpong();
    do_reset();
    fill(0, 1'b1);
    pulse_wr_done();
    for (int unsigned a = 0; a < D; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(16'h1000 + a);
      rd_en = 1'b1; rand_ports(D);
      tick();
      if (a % 64 == 0) begin
        n_cmp++; if (rd_data_np !== mdl_vec()) begin n_bad++; $display("FAIL pp_concurrent got %h exp %h", rd_data_np, mdl_vec()); end
      end
    end
    idle_inputs();
    pulse_wr_done();
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    for (int p = 0; p < NP; p++) set_port(p, 5);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    for (int p = 0; p < NP; p += 6) begin
      n_cmp++;
      if (rd_data_np[p*W +: W] !== 16'h1005) begin
        n_bad++; $display("FAIL pp_bank1_port%0d got %h exp 1005", p, rd_data_np[p*W +: W]);
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL pp_err got %b exp 0", err); end
  endtask

  task automatic test_simul_done();
    int unsigned addrs [8];
    for (int k = 0; k < 8; k++) begin
      addrs[k] = $urandom_range(D - 1, 0);
      wr_en = 1'b1; wr_addr = AW'(addrs[k]); wr_data = W'($urandom); tick();
    end
    wr_en = 1'b0;
    wr_done = 1'b1; rd_done = 1'b1; tick(); wr_done = 1'b0; rd_done = 1'b0;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL simul_wr_ready got %b exp 1", wr_ready); end
    n_cmp++; if (rd_avail !== 1'b1) begin n_bad++; $display("FAIL simul_rd_avail got %b exp 1", rd_avail); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL simul_err got %b exp 0", err); end
    for (int p = 0; p < NP; p++) set_port(p, addrs[p % 8]);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++; if (rd_data_np !== mdl_vec()) begin n_bad++; $display("FAIL simul_newbank got %h exp %h", rd_data_np, mdl_vec()); end
  endtask

  task automatic test_oor();
    rand_ports(D);
    set_port(3, 1500);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_cmp++; if (rd_data_np[3*W +: W] !== '0) begin n_bad++; $display("FAIL oor_port3 got %h exp 0", rd_data_np[3*W +: W]); end
    n_cmp++; if (rd_data_np !== mdl_vec()) begin n_bad++; $display("FAIL oor_others got %h exp %h", rd_data_np, mdl_vec()); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oor_err got %b exp 1", err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rd_en   = ($urandom_range(1, 0) == 1);
      wr_en   = ($urandom_range(9, 0) < 7);
      wr_addr = AW'($urandom_range(D + 7, 0));
      wr_data = W'($urandom);
      wr_done = ($urandom_range(199, 0) == 0);
      rd_done = ($urandom_range(149, 0) == 0);
      for (int p = 0; p < NP; p++) set_port(p, $urandom_range(D + 3, 0));
      tick();
      n_cmp++; if (rd_valid !== mdl_valid) begin n_bad++; $display("FAIL b2b_valid c%0d got %b exp %b", c, rd_valid, mdl_valid); end
      n_cmp++; if (rd_data_np !== mdl_vec()) begin n_bad++; $display("FAIL b2b_data c%0d got %h exp %h", c, rd_data_np, mdl_vec()); end
      n_cmp++; if (wr_ready !== mdl_ready()) begin n_bad++; $display("FAIL b2b_wr_ready c%0d got %b exp %b", c, wr_ready, mdl_ready()); end
      n_cmp++; if (rd_avail !== mdl_avail()) begin n_bad++; $display("FAIL b2b_rd_avail c%0d got %b exp %b", c, rd_avail, mdl_avail()); end
      n_cmp++; if (err !== mdl_err) begin n_bad++; $display("FAIL b2b_err c%0d got %b exp %b", c, err, mdl_err); end
    end
    idle_inputs();
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL %s_rd_valid got %b exp 0", tag, rd_valid); end
    n_cmp++; if (rd_data_np !== '0) begin n_bad++; $display("FAIL %s_rd_data got %h exp 0", tag, rd_data_np); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL %s_wr_ready got %b exp 1", tag, wr_ready); end
    n_cmp++; if (rd_avail !== 1'b0) begin n_bad++; $display("FAIL %s_rd_avail got %b exp 0", tag, rd_avail); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s_err got %b exp 0", tag, err); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    fill(0, 1'b0);
    pulse_wr_done();
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = W'($urandom); tick();
    end
    wr_en = 1'b0;
    wr_addr = AW'(D + 5); wr_en = 1'b1; tick(); wr_en = 1'b0;
    async_reset_check("rst_midfill");
    fill(16'h0100, 1'b0);
    pulse_wr_done();
    for (int p = 0; p < NP; p++) set_port(p, p + 1);
    rd_done = 1'b1; rd_en = 1'b1; tick(); rd_en = 1'b0; rd_done = 1'b0;
    n_cmp++; if (rd_data_np !== mdl_vec()) begin n_bad++; $display("FAIL final_read_old_bank got %h exp %h", rd_data_np, mdl_vec()); end
    rd_en = 1'b1; tick();
    async_reset_check("rst_midread");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_read();
    test_full_drop();
    test_pingpong();
    test_simul_done();
    test_oor();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
